ecc_lockstep_chk: RTL and testbench
===================================

# ecc_lockstep_chk

Pipelined, parametrised successor to the team's combinational dual-decoder ECC fault detector. Two SECDED decode cores (`ecc_cal`) run in lockstep on every accepted word. Their syndrome results are compared, and the corrected or raw data is registered into a one-entry valid/ready output stage. Adds sticky status, saturating event counters and a fault-injection self-test. Sits on the read side of ECC-protected FIFOs and RAMs, between storage and consumer.

## Interface
- `DATA_WIDTH`, 163: protected data width.
- `PARITY_WIDTH`, 9: SECDED check-bit width; must match the `ecc_cal` encoding for DATA_WIDTH.
- `CNT_WIDTH`, 16: width of each saturating event counter.
- `clk`  in  1: sole clock.
- `rst`  in  1: reset, asynchronous assert, active-high.
- `ecc_fault_detc_en`  in  1: enables lockstep compare and fault substitution.
- `bypass`  in  1: passed to both cores; no correction and no error flags.
- `inj_en`  in  1: self-test; inverts `mask[0]` of core 1 before compare.
- `cnt_clr`  in  1: synchronous clear of counters and sticky flags.
- `in_valid`  in  1, `in_ready`  out  1: input handshake.
- `data_in`  in  DATA_WIDTH, `parity_in`  in  PARITY_WIDTH: stored word and check bits.
- `out_valid`  out  1, `out_ready`  in  1: output handshake.
- `data_out`  out  DATA_WIDTH: registered corrected or raw data.
- `sbit_err`, `dbit_err`, `ecc_fault`  out  1 each: per-word flags, qualified by `out_valid`.
- `sbit_sticky`, `dbit_sticky`, `fault_sticky`  out  1 each: set on event, held until `cnt_clr`.
- `sbit_cnt`, `dbit_cnt`, `fault_cnt`  out  CNT_WIDTH each: saturating counts.

## Operation
- Accept when `in_valid & in_ready`; `in_ready = ~out_valid | out_ready` (combinational, no bubble on back-to-back traffic).
- On accept, both cores decode `data_in`/`parity_in` with the same `bypass`.
- `cmp_ok = ({sbit0,dbit0,mask0} == {sbit1,dbit1,mask1'})`, where `mask1'` is mask1 with bit 0 inverted when `inj_en`=1.
- `fault = ~cmp_ok & ecc_fault_detc_en`.
- Registered `data_out` = core-0 corrected data if `~fault`, else raw `data_in`.
- `sbit_err`/`dbit_err` always come from core 0, including on a fault word.
- Output register loads only on accept; it holds data and flags unchanged while `out_valid & ~out_ready`.
- `out_valid` is set on accept and cleared on `out_ready` with no simultaneous accept.
- Counter and sticky updates happen once per accepted word (at accept, not on output handshake):
  - sbit_cnt increments if sbit0; dbit_cnt if dbit0; fault_cnt if fault.
  - Each counter saturates at 2^CNT_WIDTH-1 and never wraps.
- `cnt_clr` has priority. In the clear cycle counters and stickies go to 0, then that cycle's accepted event is applied. Result: a counter reads 1 and the sticky reads 1 when an event coincides with the clear.
- `ecc_fault_detc_en`=0: no fault is ever flagged; data is always core-0 data; `inj_en` has no visible effect.
- `bypass`=1 is compared normally; both cores output zero flags and mask, so no fault unless `inj_en`=1.

## Timing
- Latency 1 cycle: word accepted at edge N is presented with `out_valid`=1 after edge N.
- Throughput 1 word per clock when `out_ready`=1.
- Reset (asynchronous, any time) forces all of these to 0:
  - `out_valid`, `data_out`, `sbit_err`, `dbit_err`, `ecc_fault`
  - all sticky flags and counters
- A word in flight at reset is discarded; `in_ready`=1 from the first cycle after reset.
- Mode inputs (`ecc_fault_detc_en`, `bypass`, `inj_en`) are sampled only in the accept cycle.
- Compare and mux path is combinational from input to output register. Two decoder depths in parallel plus one comparator must meet `clk`.

## Test plan
- Clean word, defaults, `out_ready`=1: encode 0x1234 with ecc_cal, send it. Next cycle `data_out`=0x1234, all flags 0, counters stay 0.
- Single-bit error: flip `data_in[100]`. `data_out` is corrected, `sbit_err`=1, `sbit_cnt`=1, `sbit_sticky`=1, `ecc_fault`=0.
- Fault injection: `inj_en`=1, detc_en=1, send clean word W with `data_in[5]` flipped. `ecc_fault`=1 and `data_out` = raw corrupted W. `fault_cnt`=1. Repeat with detc_en=0: `ecc_fault`=0 and corrected data returned.
- Backpressure: 3 back-to-back words with `out_ready`=0 for 4 cycles. Only the first is accepted; `in_ready`=0 and `data_out` stays stable. After release, the words arrive in order, one per cycle.
- Saturation and clear with CNT_WIDTH=2: 5 double-bit-error words give `dbit_cnt`=3. Assert `cnt_clr` in the same cycle as a 6th dbit word: `dbit_cnt`=1, `dbit_sticky`=1.
- Asynchronous reset mid-stream, asserted between edges with `out_valid`=1: all outputs go to 0 immediately and the word is dropped. After deassert, the first new word is delivered after 1 cycle.

Source files
------------

// File: rtl/ecc_lockstep_chk.sv
// Lockstep SECDED read-side checker: two decoder evaluations compared per accepted word,
// one-entry valid/ready output register, sticky status and saturating event counters.
module ecc_lockstep_chk #(
   parameter int unsigned DATA_WIDTH   = 163,
   parameter int unsigned PARITY_WIDTH = 9,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ecc_fault_detc_en,
   input  logic                    bypass,
   input  logic                    inj_en,
   input  logic                    cnt_clr,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic [PARITY_WIDTH-1:0] parity_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    sbit_err,
   output logic                    dbit_err,
   output logic                    ecc_fault,
   output logic                    sbit_sticky,
   output logic                    dbit_sticky,
   output logic                    fault_sticky,
   output logic [CNT_WIDTH-1:0]    sbit_cnt,
   output logic [CNT_WIDTH-1:0]    dbit_cnt,
   output logic [CNT_WIDTH-1:0]    fault_cnt
);

   localparam int unsigned HW = PARITY_WIDTH - 1;

   typedef logic [HW-1:0]           pos_t;
   typedef pos_t [DATA_WIDTH-1:0]   pos_arr_t;
   typedef logic [CNT_WIDTH-1:0]    cnt_t;
   typedef struct packed {
      logic [DATA_WIDTH-1:0] mask;
      logic                  sbit;
      logic                  dbit;
   } dec_t;

   // Hamming position of each data bit: codeword positions from 3 upward, skipping powers of two.
   function automatic pos_arr_t calc_pos();
      pos_arr_t    r;
      int unsigned p;
      r = '0;
      p = 2;
      for (int unsigned j = 0; j < DATA_WIDTH; j++) begin
         p++;
         while ((p & (p - 1)) == 0) p++;
         r[j] = pos_t'(p);
      end
      return r;
   endfunction

   localparam pos_arr_t POS = calc_pos();

   function automatic dec_t ecc_cal(input logic [DATA_WIDTH-1:0]   d,
                                    input logic [PARITY_WIDTH-1:0] p,
                                    input logic                    byp);
      dec_t r;
      pos_t syn;
      logic ovr;
      syn = p[HW-1:0];
      for (int unsigned j = 0; j < DATA_WIDTH; j++)
         if (d[j]) syn = syn ^ POS[j];
      ovr    = ^{d, p};
      r.mask = '0;
      r.sbit = 1'b0;
      r.dbit = 1'b0;
      if (!byp) begin
         r.sbit = ovr;
         r.dbit = ~ovr & (syn != '0);
         for (int unsigned j = 0; j < DATA_WIDTH; j++)
            r.mask[j] = ovr & (syn == POS[j]);
      end
      return r;
   endfunction

   function automatic cnt_t next_cnt(input cnt_t c, input logic clr, input logic ev);
      cnt_t base;
      base = clr ? '0 : c;
      if (ev && base != '1) base = base + cnt_t'(1);
      return base;
   endfunction

   dec_t                  core0, core1;
   logic [DATA_WIDTH-1:0] mask1_cmp;
   logic [DATA_WIDTH-1:0] data_corr;
   logic                  cmp_ok, fault, accept;
   logic                  ev_sbit, ev_dbit, ev_fault;

   // Two independent decoder evaluations; the lockstep compare relies on both existing.
   always_comb core0 = ecc_cal(data_in, parity_in, bypass);
   always_comb core1 = ecc_cal(data_in, parity_in, bypass);

   always_comb begin
      mask1_cmp = core1.mask ^ DATA_WIDTH'(inj_en);
      cmp_ok    = ({core0.sbit, core0.dbit, core0.mask} == {core1.sbit, core1.dbit, mask1_cmp});
      fault     = ~cmp_ok & ecc_fault_detc_en;
      data_corr = data_in ^ core0.mask;
      in_ready  = ~out_valid | out_ready;
      accept    = in_valid & in_ready;
      ev_sbit   = accept & core0.sbit;
      ev_dbit   = accept & core0.dbit;
      ev_fault  = accept & fault;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         data_out  <= '0;
         sbit_err  <= 1'b0;
         dbit_err  <= 1'b0;
         ecc_fault <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         data_out  <= fault ? data_in : data_corr;
         sbit_err  <= core0.sbit;
         dbit_err  <= core0.dbit;
         ecc_fault <= fault;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Clear wins, then the same cycle's event is applied on top of the cleared value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sbit_cnt     <= '0;
         dbit_cnt     <= '0;
         fault_cnt    <= '0;
         sbit_sticky  <= 1'b0;
         dbit_sticky  <= 1'b0;
         fault_sticky <= 1'b0;
      end else begin
         sbit_cnt     <= next_cnt(sbit_cnt, cnt_clr, ev_sbit);
         dbit_cnt     <= next_cnt(dbit_cnt, cnt_clr, ev_dbit);
         fault_cnt    <= next_cnt(fault_cnt, cnt_clr, ev_fault);
         sbit_sticky  <= (sbit_sticky & ~cnt_clr) | ev_sbit;
         dbit_sticky  <= (dbit_sticky & ~cnt_clr) | ev_dbit;
         fault_sticky <= (fault_sticky & ~cnt_clr) | ev_fault;
      end
   end

endmodule

// File: tb/tb_ecc_lockstep_chk.sv
// Scoreboard bench for ecc_lockstep_chk: expected words queued on accept, checked on output handshake.
module tb_ecc_lockstep_chk;

   localparam int unsigned DW = 163;
   localparam int unsigned PW = 9;
   localparam int unsigned CW = 2;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          sbit;
      logic          dbit;
      logic          fault;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ecc_fault_detc_en = 1'b1;
   logic          bypass = 1'b0;
   logic          inj_en = 1'b0;
   logic          cnt_clr = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] data_in = '0;
   logic [PW-1:0] parity_in = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] data_out;
   logic          sbit_err, dbit_err, ecc_fault;
   logic          sbit_sticky, dbit_sticky, fault_sticky;
   logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   exp_t        sb[$];

   ecc_lockstep_chk #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .ecc_fault_detc_en(ecc_fault_detc_en), .bypass(bypass),
      .inj_en(inj_en), .cnt_clr(cnt_clr), .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .parity_in(parity_in), .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .sbit_err(sbit_err), .dbit_err(dbit_err), .ecc_fault(ecc_fault),
      .sbit_sticky(sbit_sticky), .dbit_sticky(dbit_sticky), .fault_sticky(fault_sticky),
      .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt)
   );

   always #5 clk = ~clk;

   // Reference SECDED encoder: Hamming positions 3.. skipping powers of two, overall parity on top.
   function automatic logic [PW-1:0] enc(input logic [DW-1:0] d);
      logic [PW-1:0] p;
      int unsigned   pos;
      p   = '0;
      pos = 2;
      for (int j = 0; j < int'(DW); j++) begin
         pos++;
         while ((pos & (pos - 1)) == 0) pos++;
         for (int i = 0; i < int'(PW) - 1; i++)
            if (d[j] && pos[i]) p[i] = ~p[i];
      end
      p[PW-1] = (^d) ^ (^p[PW-2:0]);
      return p;
   endfunction

   function automatic exp_t mk(input logic [DW-1:0] d, input logic s, input logic db, input logic f);
      exp_t e;
      e.data  = d;
      e.sbit  = s;
      e.dbit  = db;
      e.fault = f;
      return e;
   endfunction

   function automatic logic [DW-1:0] rnd_word();
      return DW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
   endfunction

   always @(negedge clk) begin
      exp_t e;
      #4;
      if (!rst && out_valid && out_ready) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL out_word: unexpected output data=%h, required no output", data_out);
         end else begin
            e = sb.pop_front();
            if ({data_out, sbit_err, dbit_err, ecc_fault} !== e) begin
               n_bad++;
               $display("FAIL out_word: got data=%h s=%b d=%b f=%b, required data=%h s=%b d=%b f=%b",
                        data_out, sbit_err, dbit_err, ecc_fault, e.data, e.sbit, e.dbit, e.fault);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge, in_valid left high.
   task automatic drive(input logic [DW-1:0] d, input logic [PW-1:0] p, input exp_t e,
                        output int unsigned waits);
      waits     = 0;
      in_valid  = 1'b1;
      data_in   = d;
      parity_in = p;
      forever begin
         #4;
         if (in_ready) begin
            sb.push_back(e);
            @(negedge clk);
            break;
         end
         @(negedge clk);
         waits++;
         if (waits > 30) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready=0 for %0d cycles, required 1", waits);
            break;
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d words pending, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic clear_counters();
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      n_cmp++;
      if ({sbit_cnt, dbit_cnt, fault_cnt, sbit_sticky, dbit_sticky, fault_sticky} !== '0) begin
         n_bad++;
         $display("FAIL cnt_clr: got cnt=%0d/%0d/%0d sticky=%b%b%b, required all 0",
                  sbit_cnt, dbit_cnt, fault_cnt, sbit_sticky, dbit_sticky, fault_sticky);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      #2;
      n_cmp++;
      if ({out_valid, data_out, sbit_err, dbit_err, ecc_fault, sbit_cnt, dbit_cnt, fault_cnt,
           sbit_sticky, dbit_sticky, fault_sticky} !== '0) begin
         n_bad++;
         $display("FAIL reset_state: got out_valid=%b data=%h, required all outputs 0", out_valid, data_out);
      end
      @(negedge clk);
      rst = 1'b0;
      #4;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_clean();
      logic [DW-1:0] w;
      int unsigned   wt;
      w = DW'(16'h1234);
      drive(w, enc(w), mk(w, 1'b0, 1'b0, 1'b0), wt);
      in_valid = 1'b0;
      n_cmp++;
      if ({out_valid, data_out} !== {1'b1, w}) begin
         n_bad++;
         $display("FAIL clean_latency: got valid=%b data=%h, required valid=1 data=%h", out_valid, data_out, w);
      end
      drain();
      n_cmp++;
      if ({sbit_cnt, dbit_cnt, fault_cnt} !== '0) begin
         n_bad++;
         $display("FAIL clean_counters: got %0d/%0d/%0d, required 0/0/0", sbit_cnt, dbit_cnt, fault_cnt);
      end
   endtask

   task automatic test_sbit();
      logic [DW-1:0] w, bad;
      int unsigned   wt;
      w        = rnd_word();
      bad      = w;
      bad[100] = ~bad[100];
      drive(bad, enc(w), mk(w, 1'b1, 1'b0, 1'b0), wt);
      in_valid = 1'b0;
      drain();
      n_cmp++;
      if ({sbit_cnt, sbit_sticky, fault_cnt, fault_sticky} !== {CW'(1), 1'b1, CW'(0), 1'b0}) begin
         n_bad++;
         $display("FAIL sbit_status: got cnt=%0d sticky=%b fault_cnt=%0d, required cnt=1 sticky=1 fault_cnt=0",
                  sbit_cnt, sbit_sticky, fault_cnt);
      end
   endtask

   task automatic test_inject();
      logic [DW-1:0] w, bad;
      int unsigned   wt;
      clear_counters();
      w      = rnd_word();
      bad    = w;
      bad[5] = ~bad[5];
      inj_en = 1'b1;
      ecc_fault_detc_en = 1'b1;
      drive(bad, enc(w), mk(bad, 1'b1, 1'b0, 1'b1), wt);
      in_valid = 1'b0;
      n_cmp++;
      if ({fault_cnt, fault_sticky} !== {CW'(1), 1'b1}) begin
         n_bad++;
         $display("FAIL inj_fault_cnt: got cnt=%0d sticky=%b, required cnt=1 sticky=1", fault_cnt, fault_sticky);
      end
      ecc_fault_detc_en = 1'b0;
      drive(bad, enc(w), mk(w, 1'b1, 1'b0, 1'b0), wt);
      ecc_fault_detc_en = 1'b1;
      bypass = 1'b1;
      drive(bad, enc(w), mk(bad, 1'b0, 1'b0, 1'b1), wt);
      inj_en = 1'b0;
      drive(bad, enc(w), mk(bad, 1'b0, 1'b0, 1'b0), wt);
      in_valid = 1'b0;
      bypass   = 1'b0;
      drain();
      n_cmp++;
      if (fault_cnt !== CW'(2)) begin
         n_bad++;
         $display("FAIL inj_fault_total: got %0d, required 2", fault_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] w1, w2, w3;
      int unsigned   wt;
      w1 = rnd_word();
      w2 = rnd_word();
      w3 = rnd_word();
      out_ready = 1'b0;
      drive(w1, enc(w1), mk(w1, 1'b0, 1'b0, 1'b0), wt);
      data_in   = w2;
      parity_in = enc(w2);
      for (int c = 0; c < 4; c++) begin
         #4;
         n_cmp++;
         if ({in_ready, out_valid, data_out} !== {1'b0, 1'b1, w1}) begin
            n_bad++;
            $display("FAIL stall_%0d: got in_ready=%b valid=%b data=%h, required 0 1 %h",
                     c, in_ready, out_valid, data_out, w1);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      drive(w2, enc(w2), mk(w2, 1'b0, 1'b0, 1'b0), wt);
      n_cmp++;
      if (wt !== 0) begin
         n_bad++;
         $display("FAIL release_w2_wait: got %0d cycles, required 0", wt);
      end
      drive(w3, enc(w3), mk(w3, 1'b0, 1'b0, 1'b0), wt);
      n_cmp++;
      if (wt !== 0) begin
         n_bad++;
         $display("FAIL release_w3_wait: got %0d cycles, required 0", wt);
      end
      in_valid = 1'b0;
      drain();
   endtask

   task automatic test_saturation();
      logic [DW-1:0] w, bad;
      int unsigned   wt;
      clear_counters();
      for (int k = 0; k < 6; k++) begin
         w       = rnd_word();
         bad     = w;
         bad[10] = ~bad[10];
         bad[20] = ~bad[20];
         if (k == 5) begin
            n_cmp++;
            if (dbit_cnt !== CW'(3)) begin
               n_bad++;
               $display("FAIL dbit_saturate: got %0d, required 3", dbit_cnt);
            end
            cnt_clr = 1'b1;
         end
         drive(bad, enc(w), mk(bad, 1'b0, 1'b1, 1'b0), wt);
         cnt_clr = 1'b0;
      end
      in_valid = 1'b0;
      drain();
      n_cmp++;
      if ({dbit_cnt, dbit_sticky, sbit_sticky} !== {CW'(1), 1'b1, 1'b0}) begin
         n_bad++;
         $display("FAIL clear_with_event: got cnt=%0d sticky=%b sbit_sticky=%b, required 1 1 0",
                  dbit_cnt, dbit_sticky, sbit_sticky);
      end
   endtask

   task automatic test_reset_midstream();
      logic [DW-1:0] w;
      int unsigned   wt;
      w = rnd_word();
      out_ready = 1'b0;
      drive(w, enc(w), mk(w, 1'b0, 1'b0, 1'b0), wt);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid, data_out, sbit_err, dbit_err, ecc_fault, sbit_cnt, dbit_cnt, fault_cnt,
           sbit_sticky, dbit_sticky, fault_sticky} !== '0) begin
         n_bad++;
         $display("FAIL async_reset: got valid=%b data=%h dbit_cnt=%0d, required all 0",
                  out_valid, data_out, dbit_cnt);
      end
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      w = rnd_word();
      drive(w, enc(w), mk(w, 1'b0, 1'b0, 1'b0), wt);
      in_valid = 1'b0;
      n_cmp++;
      if ({wt, out_valid, data_out} !== {32'd0, 1'b1, w}) begin
         n_bad++;
         $display("FAIL post_reset_word: got wait=%0d valid=%b data=%h, required 0 1 %h",
                  wt, out_valid, data_out, w);
      end
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_clean();
      test_sbit();
      test_inject();
      test_back_to_back();
      test_saturation();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
